// File: rtl/memory_cycle_responder_if.sv
// Data-memory bus between the cycle responder (master) and the memory (slave).
interface memory_cycle_responder_if;
  logic [29:0] bus_address;
  logic [31:0] bus_data_out;
  logic [3:0]  bus_data_strobes;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_in;
  logic        bus_ack;

  modport master (
    output bus_address, bus_data_out, bus_data_strobes, bus_read, bus_write,
    input  bus_data_in, bus_ack
  );

  modport slave (
    input  bus_address, bus_data_out, bus_data_strobes, bus_read, bus_write,
    output bus_data_in, bus_ack
  );
endinterface

// File: rtl/memory_cycle_responder.sv
// Runs one data-memory bus cycle per pipeline request: checks alignment,
// drives big-endian strobes and lane-replicated store data, waits for
// bus_ack (with timeout) and returns zero-extended load data.
//
// state  | meaning
// IDLE   | waiting for a valid request, bus released
// ACCESS | bus_read/bus_write asserted, waiting for bus_ack
// DONE   | cycle_done pulse after a successful cycle
// ERROR  | cycle_done + bus_error pulse (misaligned, reserved width, timeout)
module memory_cycle_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       memory_access_cycle,
  input  logic                       memory_read,
  input  logic                       memory_write,
  input  logic [1:0]                 memory_cycle_width,
  input  logic [31:0]                address,
  input  logic [31:0]                write_data,
  memory_cycle_responder_if.master   bus,
  output logic [31:0]                read_data,
  output logic                       cycle_done,
  output logic                       bus_busy,
  output logic                       bus_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_WORD = 2'd1;
  localparam logic [1:0] WIDTH_LONG = 2'd2;
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [4:0]  timeout_count;
  logic [1:0]  access_width;
  logic [1:0]  access_offset;

  logic        request;
  logic        bad_request;
  logic [3:0]  strobes_next;
  logic [31:0] data_out_next;
  logic [31:0] lane_data;

  // Decode the incoming request into bus strobes/data and an error flag.
  always_comb begin
    request       = memory_access_cycle & (memory_read ^ memory_write);
    bad_request   = 1'b0;
    strobes_next  = 4'b0000;
    data_out_next = write_data;
    case (memory_cycle_width)
      WIDTH_BYTE: begin
        case (address[1:0])
          2'd0:    strobes_next = 4'b1000;
          2'd1:    strobes_next = 4'b0100;
          2'd2:    strobes_next = 4'b0010;
          default: strobes_next = 4'b0001;
        endcase
        data_out_next = {4{write_data[7:0]}};
      end
      WIDTH_WORD: begin
        bad_request   = address[0];
        strobes_next  = address[1] ? 4'b0011 : 4'b1100;
        data_out_next = {2{write_data[15:0]}};
      end
      WIDTH_LONG: begin
        bad_request   = (address[1:0] != 2'd0);
        strobes_next  = 4'b1111;
      end
      default: bad_request = 1'b1;
    endcase
  end

  // Pick the strobed lane(s) of the returning read data, zero-extended.
  always_comb begin
    lane_data = bus.bus_data_in;
    case (access_width)
      WIDTH_BYTE: begin
        case (access_offset)
          2'd0:    lane_data = {24'd0, bus.bus_data_in[31:24]};
          2'd1:    lane_data = {24'd0, bus.bus_data_in[23:16]};
          2'd2:    lane_data = {24'd0, bus.bus_data_in[15:8]};
          default: lane_data = {24'd0, bus.bus_data_in[7:0]};
        endcase
      end
      WIDTH_WORD:
        lane_data = access_offset[1] ? {16'd0, bus.bus_data_in[15:0]}
                                     : {16'd0, bus.bus_data_in[31:16]};
      default: lane_data = bus.bus_data_in;
    endcase
  end

  // Cycle sequencer with registered bus and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      timeout_count        <= 5'd0;
      access_width         <= 2'd0;
      access_offset        <= 2'd0;
      bus.bus_address      <= 30'd0;
      bus.bus_data_out     <= 32'd0;
      bus.bus_data_strobes <= 4'd0;
      bus.bus_read         <= 1'b0;
      bus.bus_write        <= 1'b0;
      read_data            <= 32'd0;
      cycle_done           <= 1'b0;
      bus_busy             <= 1'b0;
      bus_error            <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          bus_busy <= 1'b0;
          if (request) begin
            bus_busy <= 1'b1;
            if (bad_request) begin
              state      <= ERROR;
              cycle_done <= 1'b1;
              bus_error  <= 1'b1;
            end else begin
              state                <= ACCESS;
              timeout_count        <= 5'd0;
              access_width         <= memory_cycle_width;
              access_offset        <= address[1:0];
              bus.bus_address      <= address[31:2];
              bus.bus_data_strobes <= strobes_next;
              bus.bus_data_out     <= data_out_next;
              bus.bus_read         <= memory_read;
              bus.bus_write        <= memory_write;
            end
          end
        end
        ACCESS: begin
          // An ack on the final timeout cycle still completes normally.
          if (bus.bus_ack) begin
            state         <= DONE;
            bus.bus_read  <= 1'b0;
            bus.bus_write <= 1'b0;
            cycle_done    <= 1'b1;
            if (bus.bus_read) read_data <= lane_data;
          end else if (timeout_count == TIMEOUT_LAST) begin
            state         <= ERROR;
            bus.bus_read  <= 1'b0;
            bus.bus_write <= 1'b0;
            cycle_done    <= 1'b1;
            bus_error     <= 1'b1;
          end else begin
            timeout_count <= timeout_count + 5'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_cycle_responder.sv
// Randomized bench for memory_cycle_responder against a byte-lane model.
module tb_memory_cycle_responder;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        memory_access_cycle;
  logic        memory_read;
  logic        memory_write;
  logic [1:0]  memory_cycle_width;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        cycle_done;
  logic        bus_busy;
  logic        bus_error;

  memory_cycle_responder_if mem_bus ();

  memory_cycle_responder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock               (clock),
    .reset               (reset),
    .memory_access_cycle (memory_access_cycle),
    .memory_read         (memory_read),
    .memory_write        (memory_write),
    .memory_cycle_width  (memory_cycle_width),
    .address             (address),
    .write_data          (write_data),
    .bus                 (mem_bus),
    .read_data           (read_data),
    .cycle_done          (cycle_done),
    .bus_busy            (bus_busy),
    .bus_error           (bus_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_read_data = 32'd0;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] exp_strobes(input logic [1:0] width, input logic [31:0] addr);
    int off = int'(addr[1:0]);
    if (width == 2'd0) return 4'(1 << (3 - off));
    if (width == 2'd1) return 4'(3 << (2 * (1 - off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] width, input logic [31:0] wd);
    if (width == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (width == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] width, input logic [31:0] addr,
                                           input logic [31:0] din);
    int off = int'(addr[1:0]);
    if (width == 2'd0) return (din >> (8 * (3 - off))) & 32'hFF;
    if (width == 2'd1) return (din >> (16 * (1 - off / 2))) & 32'hFFFF;
    return din;
  endfunction

  // One complete request from stage 1; ack_delay >= TIMEOUT means no ack.
  task automatic do_cycle(input logic rd, input logic wr, input logic [1:0] width,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] din, input int ack_delay);
    bit invalid_alignment;
    bit acked;
    invalid_alignment = (width == 2'd3) || (width == 2'd1 && addr % 2 != 0) ||
                        (width == 2'd2 && addr % 4 != 0);
    memory_access_cycle = 1'b1;
    memory_read = rd;
    memory_write = wr;
    memory_cycle_width = width;
    address = addr;
    write_data = wd;
    step();
    if (rd == wr) begin
      check_value("ignored_busy", bus_busy, 0);
      check_value("ignored_rw", {mem_bus.bus_read, mem_bus.bus_write}, 0);
      check_value("ignored_done", cycle_done, 0);
      memory_access_cycle = 1'b0;
      step();
      return;
    end
    if (invalid_alignment) begin
      check_value("align_done", cycle_done, 1);
      check_value("align_error", bus_error, 1);
      check_value("align_rw", {mem_bus.bus_read, mem_bus.bus_write}, 0);
      check_value("align_busy", bus_busy, 1);
      check_value("align_rdata", read_data, model_read_data);
    end else begin
      acked = 0;
      for (int k = 1; k <= TIMEOUT; k++) begin
        check_value("acc_rw", {mem_bus.bus_read, mem_bus.bus_write}, {rd, wr});
        check_value("acc_addr", mem_bus.bus_address, addr >> 2);
        check_value("acc_strobes", mem_bus.bus_data_strobes, exp_strobes(width, addr));
        if (wr) check_value("acc_wdata", mem_bus.bus_data_out, exp_wdata(width, wd));
        check_value("acc_busy", bus_busy, 1);
        check_value("acc_done", cycle_done, 0);
        mem_bus.bus_ack = (k - 1 == ack_delay);
        mem_bus.bus_data_in = (k - 1 == ack_delay) ? din : $urandom;
        step();
        mem_bus.bus_ack = 1'b0;
        if (k - 1 == ack_delay) begin
          acked = 1;
          break;
        end
      end
      if (acked && rd) model_read_data = exp_read(width, addr, din);
      check_value("end_done", cycle_done, 1);
      check_value("end_error", bus_error, acked ? 0 : 1);
      check_value("end_rw", {mem_bus.bus_read, mem_bus.bus_write}, 0);
      check_value("end_busy", bus_busy, 1);
      check_value("end_rdata", read_data, model_read_data);
    end
    memory_access_cycle = 1'b0;
    step();
    check_value("idle_done", cycle_done, 0);
    check_value("idle_error", bus_error, 0);
    check_value("idle_busy", bus_busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    memory_access_cycle = 1'b0;
    memory_read = 1'b0;
    memory_write = 1'b0;
    memory_cycle_width = 2'd0;
    address = 32'd0;
    write_data = 32'd0;
    mem_bus.bus_data_in = 32'd0;
    mem_bus.bus_ack = 1'b0;
    #12;
    check_value("rst_rw", {mem_bus.bus_read, mem_bus.bus_write}, 0);
    check_value("rst_status", {cycle_done, bus_busy, bus_error}, 0);
    check_value("rst_rdata", read_data, 0);
    check_value("rst_strobes", mem_bus.bus_data_strobes, 0);
    reset = 1'b0;
    step();

    do_cycle(1, 0, 2'd2, 32'h100, 32'h0, 32'h1122_3344, 0);
    do_cycle(1, 0, 2'd0, 32'h103, 32'h0, 32'hAABB_CCDD, 0);
    do_cycle(0, 1, 2'd1, 32'h202, 32'h0000_1234, 32'h0, 2);
    do_cycle(1, 0, 2'd2, 32'h101, 32'h0, 32'hDEAD_BEEF, 0);
    do_cycle(1, 0, 2'd3, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    do_cycle(1, 0, 2'd1, 32'h0F0, 32'h0, 32'hCAFE_F00D, TIMEOUT);
    do_cycle(1, 0, 2'd1, 32'h0F0, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);
    do_cycle(0, 1, 2'd0, 32'h005, 32'h0000_00A5, 32'h0, TIMEOUT);
    do_cycle(1, 1, 2'd2, 32'h100, 32'h0, 32'h0, 0);
    do_cycle(0, 0, 2'd2, 32'h100, 32'h0, 32'h0, 0);

    // Ack while idle must not disturb anything.
    mem_bus.bus_ack = 1'b1;
    mem_bus.bus_data_in = 32'h5555_AAAA;
    step();
    mem_bus.bus_ack = 1'b0;
    check_value("stray_ack_busy", bus_busy, 0);
    check_value("stray_ack_rdata", read_data, model_read_data);

    // Reset in the middle of an access drops the bus at once.
    memory_access_cycle = 1'b1;
    memory_read = 1'b1;
    memory_write = 1'b0;
    memory_cycle_width = 2'd2;
    address = 32'h100;
    step();
    check_value("pre_rst_read", mem_bus.bus_read, 1);
    #2 reset = 1'b1;
    #1;
    check_value("mid_rst_read", mem_bus.bus_read, 0);
    check_value("mid_rst_busy", bus_busy, 0);
    model_read_data = 32'd0;
    check_value("mid_rst_rdata", read_data, 0);
    memory_access_cycle = 1'b0;
    #1 reset = 1'b0;
    step();
    do_cycle(1, 0, 2'd1, 32'h302, 32'h0, 32'h1357_9BDF, 1);

    for (int n = 0; n < 150; n++) begin
      logic rd, wr;
      logic [1:0] width;
      logic [31:0] addr;
      int delay;
      int pick;
      pick = int'($urandom_range(0, 9));
      rd = pick < 5;
      wr = !rd;
      if (pick == 9) wr = rd;
      width = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) width = 2'd3;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (width == 2'd1) addr[0] = 1'b0;
        if (width == 2'd2) addr[1:0] = 2'b00;
      end
      pick = int'($urandom_range(0, 19));
      delay = (pick == 0) ? TIMEOUT : (pick == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
      do_cycle(rd, wr, width, addr, $urandom, $urandom, delay);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
